imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 64: instruction-memory capacity in 32-bit words.
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of the first word written.
REQ-003 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port areset, input, 1: synchronous, active-high reset, sampled on the rising clk edge.
REQ-005 The block SHALL have port start, input, 1: begin a load; honoured only in IDLE, DONE or ERR.
REQ-006 The block SHALL have port in_valid, input, 1: source presents a byte.
REQ-007 The block SHALL have port in_data, input, 8: stream byte.
REQ-008 The block SHALL have port in_ready, output, 1: loader accepts a byte this cycle.
REQ-009 The block SHALL have port mem_we, output, 1: instruction-memory write strobe.
REQ-010 The block SHALL have port mem_addr, output, 32: word-aligned byte address.
REQ-011 The block SHALL have port mem_wd, output, 32: write data.
REQ-012 The block SHALL have port core_hold, output, 1: holds the core in reset while high.
REQ-013 The block SHALL have port done, output, 1: load completed successfully.
REQ-014 The block SHALL have port err, output, 1: load aborted.

Function
REQ-015 A byte SHALL be transferred exactly when in_valid and in_ready are both high at a clk edge; in_ready SHALL NOT depend combinationally on in_valid.
REQ-016 The stream format SHALL be: a 2-byte little-endian word count N, then N words of 4 bytes each, little-endian.
REQ-017 The FSM SHALL have states IDLE, HDR0, HDR1, DATA, WRITE, CKSUM (macro only), DONE and ERR.
REQ-018 In IDLE, DONE or ERR, start=1 SHALL move the FSM to HDR0 and clear the word counter, byte counter and checksum, load mem_addr with BASE_ADDR, and clear done and err.
REQ-019 While busy (HDR0 through CKSUM), start SHALL be ignored.
REQ-020 in_ready SHALL be 1 only in HDR0, HDR1, DATA and CKSUM.
REQ-021 HDR0 SHALL capture N[7:0]; HDR1 SHALL capture N[15:8].
REQ-022 On HDR1 acceptance, N==0 or N>DEPTH_WORDS SHALL go to ERR; otherwise the FSM SHALL go to DATA.
REQ-023 DATA SHALL shift each accepted byte into the word: the first byte fills bits [7:0] and the fourth fills bits [31:24].
REQ-024 On the fourth byte, the FSM SHALL go to WRITE.
REQ-025 WRITE SHALL last exactly one cycle, with mem_we=1, the assembled word on mem_wd, and in_ready=0.
REQ-026 After WRITE, mem_addr SHALL advance by 4 and the word counter by 1.
REQ-027 After WRITE, if the count equals N the FSM SHALL go to CKSUM (macro defined) or to DONE; otherwise it SHALL go to DATA.
REQ-028 Outside WRITE, mem_we SHALL be 0.
REQ-029 mem_addr wrap-around SHALL be unreachable because N<=DEPTH_WORDS is enforced.
REQ-030 core_hold SHALL be 1 in every state except DONE.
REQ-031 done SHALL be 1 only in DONE; err SHALL be 1 only in ERR.
REQ-032 DONE and ERR SHALL be held until start or areset.
REQ-033 When no bytes are offered, the FSM SHALL wait indefinitely with no timeout.

Reset
REQ-034 areset=1 SHALL force IDLE regardless of state, including mid-word or mid-WRITE.
REQ-035 Reset values SHALL be: in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wd=0, core_hold=1, done=0, err=0; all counters and the checksum SHALL be 0.
REQ-036 A partially assembled word SHALL be discarded on reset and SHALL never be written.

Configuration
REQ-037 Macro IMEM_LOADER_CKSUM_EN, when defined, SHALL compile in a running XOR of all data bytes (header excluded) and the CKSUM state.
REQ-038 With the macro defined, CKSUM SHALL accept one byte: a match goes to DONE and a mismatch goes to ERR.
REQ-039 With the macro undefined, no checksum logic or CKSUM state SHALL exist, and DONE SHALL follow the final WRITE directly.

Structure
REQ-040 Package imem_loader_pkg SHALL hold the FSM state encoding, the header byte count (2), the bytes-per-word constant (4) and the address increment constant (4).
REQ-041 Sub-module imem_loader_asm SHALL implement the byte-to-word shift register with a 2-bit byte counter and a word_full pulse; imem_loader SHALL hold the FSM, counters and memory port.

Verification
REQ-042 The bench SHALL check that start, then bytes 01 00 13 05 A0 00, produces one write with mem_addr=0x0 and mem_wd=0x00A00513, followed by done=1 and core_hold=0.
REQ-043 The bench SHALL check that N=3 with in_valid toggled every other cycle produces writes at 0x0, 0x4 and 0x8 in order, and that in_ready=0 during each WRITE.
REQ-044 The bench SHALL check that header 00 00 produces err=1 and no mem_we, and that header 41 00 with DEPTH_WORDS=64 produces err=1.
REQ-045 The bench SHALL check that asserting areset after the 2nd data byte yields IDLE with no mem_we, and that a following full load writes correct data at BASE_ADDR.
REQ-046 The bench SHALL check that start pulsed mid-load is ignored, and that start in DONE restarts the load with mem_addr reloaded to BASE_ADDR.
REQ-047 With IMEM_LOADER_CKSUM_EN defined, the bench SHALL check that word 0x00A00513 followed by checksum byte B6 gives done=1, and that checksum byte B7 gives err=1 with core_hold=1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: state encoding and stream constants shared by the loader files.
// The CKSUM state only exists when IMEM_LOADER_CKSUM_EN is defined.
package imem_loader_pkg;
   typedef enum logic [2:0] {
      IDLE,
      HDR0,
      HDR1,
      DATA,
      WRITE,
`ifdef IMEM_LOADER_CKSUM_EN
      CKSUM,
`endif
      DONE,
      ERR
   } loaderState_t;
   localparam int HDR_BYTES = 2;
   localparam int BYTES_PER_WORD = 4;
   localparam logic [31:0] ADDR_INC = 32'd4;
   function automatic logic isIdle(input loaderState_t s);
      return s == IDLE || s == DONE || s == ERR;
   endfunction
endpackage

// File: rtl/imem_loader_asm.sv
// imem_loader_asm: assembles little-endian stream bytes into 32-bit words.
// wordFull pulses in the cycle the last byte of a word is shifted in.
module imem_loader_asm
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        areset,
   input  logic        clear,
   input  logic        shiftEn,
   input  logic [7:0]  byteIn,
   output logic [31:0] word,
   output logic        wordFull
);
   logic [1:0] byteCnt;
   assign wordFull = shiftEn && byteCnt == 2'(BYTES_PER_WORD - 1);
   always_ff @(posedge clk) begin
      if (areset || clear) begin
         word <= '0;
         byteCnt <= '0;
      end else if (shiftEn) begin
         word <= {byteIn, word[31:8]};
         byteCnt <= byteCnt + 2'd1;
      end
   end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a counted word image into instruction memory while holding the core.
// Define IMEM_LOADER_CKSUM_EN to append and verify an XOR checksum byte after the data.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int          DEPTH_WORDS = 64,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        areset,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wd,
   output logic        core_hold,
   output logic        done,
   output logic        err
);
`ifdef IMEM_LOADER_CKSUM_EN
   localparam loaderState_t AFTER_LAST = CKSUM;
   logic [7:0] cksum;
`else
   localparam loaderState_t AFTER_LAST = DONE;
`endif
   loaderState_t state, nextState;
   logic [15:0] nWords, wordCnt, hdrCount;
   logic        accept, restart, wordFull;
   assign restart = start && isIdle(state);
   assign accept = in_valid && in_ready;
   assign hdrCount = {in_data, nWords[7:0]};
   assign mem_we = state == WRITE;
   assign core_hold = state != DONE;
   assign done = state == DONE;
   assign err = state == ERR;
   always_comb begin
      in_ready = state inside {HDR0, HDR1, DATA};
`ifdef IMEM_LOADER_CKSUM_EN
      in_ready = in_ready || state == CKSUM;
`endif
   end
   imem_loader_asm u_asm (
      .clk      (clk),
      .areset   (areset),
      .clear    (restart),
      .shiftEn  (accept && state == DATA),
      .byteIn   (in_data),
      .word     (mem_wd),
      .wordFull (wordFull)
   );
   always_comb begin
      nextState = state;
      case (state)
         IDLE, DONE, ERR: if (start) nextState = HDR0;
         HDR0: if (accept) nextState = HDR1;
         HDR1: if (accept) nextState = (hdrCount == '0 || hdrCount > 16'(DEPTH_WORDS)) ? ERR : DATA;
         DATA: if (wordFull) nextState = WRITE;
         WRITE: nextState = (wordCnt + 16'd1 == nWords) ? AFTER_LAST : DATA;
`ifdef IMEM_LOADER_CKSUM_EN
         CKSUM: if (accept) nextState = (in_data == cksum) ? DONE : ERR;
`endif
         default: nextState = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (areset) begin
         state <= IDLE;
         nWords <= '0;
         wordCnt <= '0;
         mem_addr <= BASE_ADDR;
      end else begin
         state <= nextState;
         if (restart) begin
            nWords <= '0;
            wordCnt <= '0;
            mem_addr <= BASE_ADDR;
         end
         if (accept && state == HDR0) nWords[7:0] <= in_data;
         if (accept && state == HDR1) nWords[15:8] <= in_data;
         if (state == WRITE) begin
            mem_addr <= mem_addr + ADDR_INC;
            wordCnt <= wordCnt + 16'd1;
         end
      end
   end
`ifdef IMEM_LOADER_CKSUM_EN
   always_ff @(posedge clk) begin
      if (areset || restart) cksum <= '0;
      else if (accept && state == DATA) cksum <= cksum ^ in_data;
   end
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized loads checked against a queue-based model of the stream format.
module tb_imem_loader;
   localparam int          DEPTH = 64;
   localparam logic [31:0] BASE = 32'h0000_0000;
   logic clk = 0, areset = 1, start = 0, in_valid = 0;
   logic [7:0]  in_data = 0;
   logic        in_ready, mem_we, core_hold, done, err;
   logic [31:0] mem_addr, mem_wd;
   int checks = 0, failures = 0, writes = 0, w0;
   logic [7:0]  stream[$];
   logic [31:0] words[$];
   logic [63:0] expQ[$];
   logic [31:0] lastWd = 0;
   bit expDone;

   imem_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk(clk), .areset(areset), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
      .core_hold(core_hold), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", tag, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (mem_we) begin
         if (expQ.size() == 0) check("stray_we", 1, 0);
         else begin
            logic [63:0] e;
            e = expQ.pop_front();
            check("we_addr", mem_addr, e[63:32]);
            check("we_data", mem_wd, e[31:0]);
            check("we_rdy", {31'd0, in_ready}, 0);
            lastWd = mem_wd;
            writes++;
         end
      end
   end

   task automatic fillWords(input int n);
      words = {};
      repeat (n) words.push_back($urandom);
   endtask

   // Model: header, words little-endian, optional XOR byte; writes land at BASE + 4*i.
   task automatic planLoad(input int n, input bit badCk);
      logic [7:0] ck = 0;
      stream = {};
      stream.push_back(n[7:0]);
      stream.push_back(n[15:8]);
      expDone = n >= 1 && n <= DEPTH;
      if (expDone) begin
         for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
               stream.push_back(words[i][8*k +: 8]);
               ck ^= words[i][8*k +: 8];
            end
            expQ.push_back({BASE + 32'(4 * i), words[i]});
         end
      end
`ifdef IMEM_LOADER_CKSUM_EN
      if (expDone) begin
         stream.push_back(badCk ? ck ^ 8'h01 : ck);
         expDone = !badCk;
      end
`endif
   endtask

   task automatic pulseStart();
      @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
   endtask

   task automatic sendByte(input logic [7:0] b, input int gap);
      int tries = 0;
      repeat (gap) @(negedge clk);
      in_valid = 1;
      in_data = b;
      while (!in_ready && tries < 50) begin
         @(negedge clk);
         tries++;
      end
      if (tries >= 50) check("rdy_timeout", 0, 1);
      @(negedge clk);
      in_valid = 0;
   endtask

   task automatic waitStatus();
      int t = 0;
      while (!(done || err) && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("done", {31'd0, done}, {31'd0, expDone});
      check("err", {31'd0, err}, {31'd0, !expDone});
      check("core_hold", {31'd0, core_hold}, {31'd0, !expDone});
      repeat (3) @(negedge clk);
      check("status_held", {30'd0, done, err}, {30'd0, expDone, !expDone});
      check("pending_writes", expQ.size(), 0);
   endtask

   task automatic runLoad(input int gapMode, input int midStartAt);
      pulseStart();
      check("start_rdy", {31'd0, in_ready}, 1);
      check("start_addr", mem_addr, BASE);
      foreach (stream[i]) begin
         if (i == midStartAt) begin
            start = 1;
            @(negedge clk);
            start = 0;
         end
         sendByte(stream[i], gapMode == 2 ? int'($urandom_range(0, 2)) : gapMode);
      end
      waitStatus();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rdy", {31'd0, in_ready}, 0);
      check("rst_we", {31'd0, mem_we}, 0);
      check("rst_addr", mem_addr, BASE);
      check("rst_wd", mem_wd, 0);
      check("rst_hold", {31'd0, core_hold}, 1);
      check("rst_done", {31'd0, done}, 0);
      check("rst_err", {31'd0, err}, 0);
      areset = 0;
      words = {32'h00A00513};
      planLoad(1, 0);
      w0 = writes;
      runLoad(0, -1);
      check("fixed_wd", lastWd, 32'h00A00513);
      check("fixed_writes", writes - w0, 1);
      fillWords(3);
      planLoad(3, 0);
      w0 = writes;
      runLoad(1, -1);
      check("n3_writes", writes - w0, 3);
      words = {};
      planLoad(0, 0);
      runLoad(0, -1);
      planLoad(DEPTH + 1, 0);
      runLoad(0, -1);
      fillWords(4);
      planLoad(4, 0);
      runLoad(2, 7);
      fillWords(2);
      planLoad(2, 0);
      runLoad(0, -1);
      fillWords(2);
      planLoad(2, 0);
      pulseStart();
      for (int i = 0; i < 4; i++) sendByte(stream[i], 0);
      @(negedge clk);
      areset = 1;
      @(negedge clk);
      areset = 0;
      expQ = {};
      check("mid_rst_rdy", {31'd0, in_ready}, 0);
      check("mid_rst_hold", {31'd0, core_hold}, 1);
      check("mid_rst_status", {30'd0, done, err}, 0);
      check("mid_rst_addr", mem_addr, BASE);
      check("mid_rst_wd", mem_wd, 0);
      repeat (4) @(negedge clk);
      fillWords(3);
      planLoad(3, 0);
      runLoad(2, -1);
      for (int r = 0; r < 6; r++) begin
         fillWords(int'($urandom_range(1, 8)));
         planLoad(words.size(), 1'($urandom_range(0, 1)));
         runLoad(2, -1);
      end
      fillWords(DEPTH);
      planLoad(DEPTH, 0);
      runLoad(0, -1);
`ifdef IMEM_LOADER_CKSUM_EN
      words = {32'h00A00513};
      planLoad(1, 1);
      runLoad(0, -1);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
